// File: rtl/card_arb_pkg.sv
// rtl/card_arb_pkg.sv - shared state encodings, card range and requester IDs for the card request arbiter
package card_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_t;

    localparam logic [3:0] CARD_MIN = 4'd1;
    localparam logic [3:0] CARD_MAX = 4'd13;

    localparam logic PLAYER = 1'b0;
    localparam logic DEALER = 1'b1;

    function automatic logic card_legal(input logic [3:0] card);
        return (card >= CARD_MIN) && (card <= CARD_MAX);
    endfunction

endpackage

// File: rtl/card_request_arbiter_if.sv
// rtl/card_request_arbiter_if.sv - request, card-source and status bundle of the card request arbiter
interface card_request_arbiter_if;

    logic       req_player_i;
    logic       req_dealer_i;
    logic       shuffle_i;
    logic       card_req_o;
    logic       card_valid_i;
    logic [3:0] card_i;
    logic [3:0] card_o;
    logic       ack_player_o;
    logic       ack_dealer_o;
    logic [5:0] draws_o;
    logic       deck_empty_o;
    logic       err_o;
    logic [1:0] state_o;

    modport slave (
        input  req_player_i, req_dealer_i, shuffle_i, card_valid_i, card_i,
        output card_req_o, card_o, ack_player_o, ack_dealer_o,
               draws_o, deck_empty_o, err_o, state_o
    );

    modport master (
        output req_player_i, req_dealer_i, shuffle_i, card_valid_i, card_i,
        input  card_req_o, card_o, ack_player_o, ack_dealer_o,
               draws_o, deck_empty_o, err_o, state_o
    );

endinterface

// File: rtl/card_arb_rr_pick.sv
// rtl/card_arb_rr_pick.sv - two-way round-robin pick between player and dealer pending flags
module card_arb_rr_pick (
    input  logic pend_player,
    input  logic pend_dealer,
    input  logic last_grant,
    output logic grant
);
    import card_arb_pkg::*;

    // On a tie the side that was not served last goes first.
    always_comb begin
        grant = PLAYER;
        if (pend_player && pend_dealer) begin
            grant = ~last_grant;
        end else if (pend_dealer) begin
            grant = DEALER;
        end
    end

endmodule

// File: rtl/card_request_arbiter.sv
// rtl/card_request_arbiter.sv - arbitrates player/dealer card draws against a random card source
// Optional WAIT timeout with err_o strobe enabled by macro CARD_ARB_TIMEOUT_EN.
module card_request_arbiter #(
    parameter int MAX_CARDS   = 52,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                         clk_arb_i,
    input  logic                         rst_arb_i,
    card_request_arbiter_if.slave        bus
);
    import card_arb_pkg::*;

    localparam logic [5:0] DECK_SIZE = 6'(MAX_CARDS);

    arb_state_t state_q, state_d;
    logic       pend_player_q, pend_dealer_q;
    logic       last_grant_q, grant_q, grant_pick;
    logic [3:0] card_q;
    logic [5:0] draws_q;
    logic       deck_empty;
    logic       ack_player, ack_dealer;
    logic       timeout;

    card_arb_rr_pick u_rr_pick (
        .pend_player (pend_player_q),
        .pend_dealer (pend_dealer_q),
        .last_grant  (last_grant_q),
        .grant       (grant_pick)
    );

    assign deck_empty = (draws_q == DECK_SIZE);
    assign ack_player = (state_q == ST_DELIVER) && (grant_q == PLAYER);
    assign ack_dealer = (state_q == ST_DELIVER) && (grant_q == DEALER);

`ifdef CARD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    always_ff @(posedge clk_arb_i or posedge rst_arb_i) begin
        if (rst_arb_i) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_q == ST_WAIT && !timeout) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    assign bus.err_o = err_q;
`else
    wire unused_timeout_cfg = |32'(TIMEOUT_CYC);

    assign bus.err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((pend_player_q || pend_dealer_q) && !deck_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Out-of-range ranks are dropped and the source is asked again.
                if (bus.card_valid_i) begin
                    state_d = card_legal(bus.card_i) ? ST_DELIVER : ST_REQ;
                end
`ifdef CARD_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_DELIVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_arb_i or posedge rst_arb_i) begin
        if (rst_arb_i) begin
            state_q       <= ST_IDLE;
            pend_player_q <= 1'b0;
            pend_dealer_q <= 1'b0;
            last_grant_q  <= DEALER;
            grant_q       <= PLAYER;
            card_q        <= 4'd0;
            draws_q       <= 6'd0;
        end else begin
            state_q <= state_d;
            // A new pulse wins over the ack that would clear the flag.
            pend_player_q <= bus.req_player_i | (pend_player_q & ~ack_player);
            pend_dealer_q <= bus.req_dealer_i | (pend_dealer_q & ~ack_dealer);
            if (state_q == ST_IDLE && state_d == ST_REQ) begin
                grant_q <= grant_pick;
            end
            if (state_q == ST_WAIT && bus.card_valid_i && card_legal(bus.card_i)) begin
                card_q <= bus.card_i;
            end
            if (state_q == ST_DELIVER) begin
                last_grant_q <= grant_q;
            end
            if (bus.shuffle_i) begin
                draws_q <= 6'd0;
            end else if (state_q == ST_DELIVER && draws_q != DECK_SIZE) begin
                draws_q <= draws_q + 6'd1;
            end
        end
    end

    assign bus.card_req_o   = (state_q == ST_REQ);
    assign bus.card_o       = card_q;
    assign bus.ack_player_o = ack_player;
    assign bus.ack_dealer_o = ack_dealer;
    assign bus.draws_o      = draws_q;
    assign bus.deck_empty_o = deck_empty;
    assign bus.state_o      = state_q;

endmodule
